// File: rtl/des_sbox_engine.sv
// des_sbox_engine: DES substitution stage (S1..S8), 48-bit in -> 32-bit out.
// LANES S-box lookups per cycle, so one block takes ROUNDS = 8/LANES busy cycles.
// Optional feature macro: DES_SBOX_PERM_EN applies the DES P-permutation to the
// result as it is loaded into out_data (latency unchanged).
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high. The producer holds in_valid/in_data until in_ready; out_data/out_valid
// stay stable until out_ready. in_ready depends combinationally on out_ready so
// a finished block can leave in the same cycle a new block enters.
module des_sbox_engine #(
    parameter int LANES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [47:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        busy,
    output logic [1:0]  dbg_state
);
    localparam int ROUNDS = 8 / LANES;
    localparam int CW     = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;

    localparam logic [1:0]    S_IDLE = 2'd0;
    localparam logic [1:0]    S_BUSY = 2'd1;
    localparam logic [1:0]    S_DONE = 2'd2;
    localparam logic [CW-1:0] LAST   = CW'(ROUNDS - 1);

    generate
        if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8) begin : g_bad_lanes
            $error("des_sbox_engine: LANES must be 1, 2, 4 or 8");
        end
    endgenerate

    logic [1:0]    r_state;
    logic [CW-1:0] r_count;
    logic [47:0]   r_data;
    logic [31:0]   r_result;
    logic [31:0]   r_out_data;
    logic [31:0]   w_result_next;
    logic [31:0]   w_out_next;
    logic          w_accept;

    // Each table is 64 nibbles, row-major (row 0 col 0 in the top nibble).
    // The 6-bit chunk addresses it as row = {b5,b0}, col = b4:b1.
    function automatic logic [3:0] sbox_lookup(input logic [2:0] box, input logic [5:0] chunk);
        logic [255:0] tbl;
        logic [5:0]   idx;
        logic [7:0]   base;
        idx = {chunk[5], chunk[0], chunk[4:1]};
        case (box)
            3'd0: tbl = {64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538,
                         64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D};
            3'd1: tbl = {64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5,
                         64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9};
            3'd2: tbl = {64'hA09E63F51DC7B428, 64'hD709346A285ECBF1,
                         64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C};
            3'd3: tbl = {64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9,
                         64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E};
            3'd4: tbl = {64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986,
                         64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453};
            3'd5: tbl = {64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38,
                         64'h9EF528C3704A1DB6, 64'h432C95FABE17608D};
            3'd6: tbl = {64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86,
                         64'h14BDC37EAF680592, 64'h6BD814A7950FE23C};
            3'd7: tbl = {64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92,
                         64'h7B419CE206ADF358, 64'h21E74A8DFC90356B};
            default: tbl = '0;
        endcase
        base = 8'd252 - {idx, 2'b00};
        sbox_lookup = tbl[base +: 4];
    endfunction

`ifdef DES_SBOX_PERM_EN
    // FIPS 46-3 P table: output bit i (1 = MSB) takes input bit P[i].
    function automatic logic [31:0] p_perm(input logic [31:0] s);
        p_perm = {s[16], s[25], s[12], s[11], s[3],  s[20], s[4],  s[15],
                  s[31], s[17], s[9],  s[6],  s[27], s[14], s[1],  s[22],
                  s[30], s[24], s[8],  s[18], s[0],  s[5],  s[29], s[23],
                  s[13], s[19], s[2],  s[26], s[10], s[21], s[28], s[7]};
    endfunction
    assign w_out_next = p_perm(w_result_next);
`else
    assign w_out_next = w_result_next;
`endif

    // Look up this cycle's LANES chunks (k = count*LANES + l) into their result nibbles.
    always_comb begin
        w_result_next = r_result;
        for (int l = 0; l < LANES; l++) begin
            w_result_next[5'(28 - 4 * (int'(r_count) * LANES + l)) +: 4] =
                sbox_lookup(3'(int'(r_count) * LANES + l),
                            r_data[6'(42 - 6 * (int'(r_count) * LANES + l)) +: 6]);
        end
    end

    // clear blocks acceptance in the same cycle, so in_ready drops with it.
    assign in_ready  = rst_n & ~clear &
                       ((r_state == S_IDLE) | ((r_state == S_DONE) & out_ready));
    assign w_accept  = in_valid & in_ready;
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state == S_BUSY);
    assign out_data  = r_out_data;
    assign dbg_state = r_state;

    // IDLE/BUSY/DONE control, block capture and result accumulation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_count    <= '0;
            r_data     <= '0;
            r_result   <= '0;
            r_out_data <= '0;
        end else if (clear) begin
            r_state <= S_IDLE;
            r_count <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_data  <= in_data;
                        r_count <= '0;
                        r_state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    r_result <= w_result_next;
                    r_count  <= r_count + 1'b1;
                    if (r_count == LAST) begin
                        r_state    <= S_DONE;
                        r_out_data <= w_out_next;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        if (w_accept) begin
                            r_data  <= in_data;
                            r_count <= '0;
                            r_state <= S_BUSY;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_des_sbox_engine.sv
// Bench for des_sbox_engine: one instance per LANES value (1,2,4,8); tests run on
// the instance chosen by sel. Honours DES_SBOX_PERM_EN in its reference model.
module tb_des_sbox_engine;
    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        clear;
    logic [47:0] in_data;
    logic [3:0]  in_valid_v;
    logic [3:0]  in_ready_v;
    logic [3:0]  out_valid_v;
    logic [3:0]  out_ready_v;
    logic [3:0]  busy_v;
    logic [31:0] out_data_v [4];
    logic [1:0]  dbg_v [4];

    int sel;
    int rounds;
    int n_tests = 0;
    int n_fail  = 0;

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_dut
            des_sbox_engine #(.LANES(1 << g)) u_dut (
                .clk      (clk),
                .rst_n    (rst_n),
                .clear    (clear),
                .in_valid (in_valid_v[g]),
                .in_ready (in_ready_v[g]),
                .in_data  (in_data),
                .out_valid(out_valid_v[g]),
                .out_ready(out_ready_v[g]),
                .out_data (out_data_v[g]),
                .busy     (busy_v[g]),
                .dbg_state(dbg_v[g])
            );
        end
    endgenerate

    // ---------------- reference model ----------------
    int sbox_tab [8][64] = '{
        '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7,  0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
          4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0,  15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
        '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10,  3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
          0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15,  13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
        '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8,  13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
          13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7,  1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
        '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15,  13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
          10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4,  3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
        '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9,  14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
          4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14,  11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
        '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11,  10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
          9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6,  4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
        '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1,  13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
          1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2,  6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
        '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7,  1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
          7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8,  2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}
    };
    int p_tab [32] = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
                       2,8,24,14,32,27,3,9,    19,13,30,6,22,11,4,25};

    function automatic logic [31:0] model(input logic [47:0] x);
        logic [31:0] s;
        logic [31:0] p;
        int c;
        int row;
        int col;
        s = '0;
        for (int k = 0; k < 8; k++) begin
            c   = int'((x >> (42 - 6 * k)) & 48'h3F);
            row = (c / 32) * 2 + (c % 2);
            col = (c / 2) % 16;
            s   = s | (32'(sbox_tab[k][row * 16 + col]) << (28 - 4 * k));
        end
        p = s;
`ifdef DES_SBOX_PERM_EN
        for (int i = 1; i <= 32; i++) p[32 - i] = s[32 - p_tab[i - 1]];
`endif
        return p;
    endfunction

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];
    logic [47:0] vec_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (lanes=%0d t=%0t)", name, act, exp, 1 << sel, $time);
        end
    endtask

    // Every cycle the selected engine shows out_valid, its data must be the head
    // of the expected queue; the head retires when out_ready completes the transfer.
    always @(negedge clk) begin
        if (rst_n && !clear && out_valid_v[sel]) begin
            if (exp_q.size() == 0) begin
                check("sb_spurious_out", 32'd1, 32'd0);
            end else begin
                check("sb_data", out_data_v[sel], exp_q[0]);
                if (out_ready_v[sel]) void'(exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic select(input int s);
        sel    = s;
        rounds = 8 >> s;
    endtask

    // Present d, wait (bounded) for in_ready, then let the accepting edge pass.
    task automatic send_wait(input logic [47:0] d);
        int gd;
        in_data         = d;
        in_valid_v[sel] = 1'b1;
        gd = 0;
        @(negedge clk);
        while (!in_ready_v[sel] && gd < 100) begin
            @(negedge clk);
            gd++;
        end
        if (gd >= 100) check("accept_timeout", 32'd0, 32'd1);
        exp_q.push_back(model(d));
        tick();
        in_valid_v[sel] = 1'b0;
    endtask

    // Called just after the accept edge; returns the edge count until out_valid.
    task automatic wait_out_valid(output int e);
        e = 0;
        @(negedge clk);
        while (!out_valid_v[sel] && e < 40) begin
            @(negedge clk);
            e++;
        end
    endtask

    task automatic drain();
        tick();
        out_ready_v[sel] = 1'b1;
        tick();
        out_ready_v[sel] = 1'b0;
    endtask

    task automatic one_block(input logic [47:0] d, input logic [31:0] lit, input string name);
        int e;
        out_ready_v[sel] = 1'b0;
        send_wait(d);
        wait_out_valid(e);
        check({name, "_latency"}, e, rounds);
`ifndef DES_SBOX_PERM_EN
        check({name, "_literal"}, out_data_v[sel], lit);
`endif
        drain();
    endtask

    // Streams vec_q through the selected engine, optionally with random out_ready stalls.
    task automatic run_stream(input bit stall);
        int sent;
        int n;
        int guard;
        sent  = 0;
        n     = vec_q.size();
        guard = 0;
        while ((sent < n || exp_q.size() != 0) && guard < 5000) begin
            in_valid_v[sel]  = (sent < n);
            in_data          = (sent < n) ? vec_q[sent] : 48'h0;
            out_ready_v[sel] = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            @(negedge clk);
            if (in_valid_v[sel] && in_ready_v[sel]) begin
                exp_q.push_back(model(vec_q[sent]));
                sent++;
            end
            tick();
            guard++;
        end
        in_valid_v[sel]  = 1'b0;
        out_ready_v[sel] = 1'b0;
        check("stream_done_in_budget", 32'(guard < 5000), 32'd1);
        check("stream_all_sent", sent, n);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int e;
        rst_n       = 1'b0;
        clear       = 1'b0;
        in_data     = '0;
        in_valid_v  = '0;
        out_ready_v = '0;
        select(2);
        #1;
        for (int i = 0; i < 4; i++) begin
            check("reset_out_valid", out_valid_v[i], 32'd0);
            check("reset_out_data", out_data_v[i], 32'd0);
            check("reset_busy", busy_v[i], 32'd0);
            check("reset_in_ready", in_ready_v[i], 32'd0);
        end

`ifndef DES_SBOX_PERM_EN
        check("model_pin_zero", model(48'h0), 32'hEFA72C4D);
        check("model_pin_ones", model(48'hFFFF_FFFF_FFFF), 32'hD9CE3DCB);
        check("model_pin_row1", model(48'h041041041041), 32'h03DDEAD1);
        check("model_pin_row2", model(48'h820820820820), 32'h40DA4917);
`endif

        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("idle_in_ready", in_ready_v[sel], 32'd1);
        tick();

        // 1: all-zero block, LANES=4
        select(2);
        one_block(48'h0, 32'hEFA72C4D, "t1_zero");

        // 2: all-ones block, LANES=1
        select(0);
        one_block(48'hFFFF_FFFF_FFFF, 32'hD9CE3DCB, "t2_ones");

        // LANES=8 single busy cycle, LANES=2 with another row
        select(3);
        one_block(48'h041041041041, 32'h03DDEAD1, "t_l8_row1");
        select(1);
        one_block(48'h820820820820, 32'h40DA4917, "t_l2_row2");

        // 3: output stall then back-to-back accept, LANES=4
        select(2);
        out_ready_v[sel] = 1'b0;
        send_wait(48'h0123_4567_89AB);
        wait_out_valid(e);
        check("t3_latency_a", e, rounds);
        for (int i = 0; i < 5; i++) begin
            tick();
            @(negedge clk);
            check("t3_hold_valid", out_valid_v[sel], 32'd1);
            check("t3_hold_data", out_data_v[sel], model(48'h0123_4567_89AB));
            check("t3_hold_in_ready", in_ready_v[sel], 32'd0);
        end
        tick();
        out_ready_v[sel] = 1'b1;
        in_valid_v[sel]  = 1'b1;
        in_data          = 48'hFEDC_BA98_7654;
        @(negedge clk);
        check("t3_in_ready_comb", in_ready_v[sel], 32'd1);
        exp_q.push_back(model(48'hFEDC_BA98_7654));
        tick();
        in_valid_v[sel]  = 1'b0;
        out_ready_v[sel] = 1'b0;
        wait_out_valid(e);
        check("t3_latency_b", e, rounds);
        drain();

        // 4: clear at BUSY count=1 with in_valid high, LANES=2
        select(1);
        out_ready_v[sel] = 1'b0;
        send_wait(48'h1111_2222_3333);
        tick();
        clear           = 1'b1;
        in_valid_v[sel] = 1'b1;
        in_data         = 48'h4444_5555_6666;
        @(negedge clk);
        check("t4_busy_before_clear", busy_v[sel], 32'd1);
        check("t4_no_ready_in_clear", in_ready_v[sel], 32'd0);
        tick();
        clear           = 1'b0;
        in_valid_v[sel] = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("t4_idle_after_clear", busy_v[sel], 32'd0);
        check("t4_in_ready_idle", in_ready_v[sel], 32'd1);
        for (int i = 0; i < 6; i++) begin
            check("t4_no_out_valid", out_valid_v[sel], 32'd0);
            @(negedge clk);
        end
        tick();
        one_block(48'h820820820820, 32'h40DA4917, "t4_after_clear");

        // 5: async reset mid-BUSY, LANES=1
        select(0);
        out_ready_v[sel] = 1'b0;
        send_wait(48'hABCD_EF01_2345);
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_out_valid", out_valid_v[sel], 32'd0);
        check("t5_rst_busy", busy_v[sel], 32'd0);
        check("t5_rst_in_ready", in_ready_v[sel], 32'd0);
        check("t5_rst_out_data", out_data_v[sel], 32'd0);
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t5_no_partial", out_valid_v[sel], 32'd0);
        end
        tick();
        one_block(48'h0, 32'hEFA72C4D, "t5_after_reset");

        // 6: streams on every LANES value, stalled and unstalled
        for (int s = 0; s < 4; s++) begin
            select(s);
            vec_q.delete();
            vec_q.push_back(48'h0);
            vec_q.push_back(48'hFFFF_FFFF_FFFF);
            vec_q.push_back(48'hAAAA_AAAA_AAAA);
            vec_q.push_back(48'h5555_5555_5555);
            vec_q.push_back(48'h041041041041);
            vec_q.push_back(48'h820820820820);
            for (int i = 0; i < 24; i++) vec_q.push_back({16'($urandom()), 32'($urandom())});
            run_stream(1'b1);
            run_stream(1'b0);
        end

        check("queue_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
